// File: rtl/data_mem_mmio_pkg.sv
// Shared constants for data_mem_mmio: I/O window register offsets and the
// hexadecimal seven-segment glyph table.
//   OFF_*    : word offsets from IO_BASE of each memory-mapped register
//   HEX_SEG  : active-high segment patterns {g,f,e,d,c,b,a} for 0..F
package data_mem_mmio_pkg;

  localparam logic [3:0] OFF_LED      = 4'h4;
  localparam logic [3:0] OFF_SEG_LO   = 4'h5;
  localparam logic [3:0] OFF_SEG_HI   = 4'h6;
  localparam logic [3:0] OFF_SEG_CTL  = 4'h7;
  localparam logic [3:0] OFF_BTN_EDGE = 4'hC;
  localparam logic [3:0] OFF_BTN_LVL  = 4'hD;
  localparam logic [3:0] OFF_SW       = 4'hE;

  // Segment a is bit 0. The decimal point is not part of a glyph; it is
  // supplied per digit from the control register.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return HEX_SEG[nib];
  endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Load/store port between the CPU datapath and data_mem_mmio.
//   address      : word address
//   read_en      : read request
//   write_en     : write request
//   input_data   : write data
//   output_data  : registered read data (holds between reads)
//   read_valid   : one-cycle strobe, output_data has just been updated
//   access_err   : one-cycle strobe, illegal or colliding access
//
// Handshake: read_en/write_en are single-cycle requests that the slave
// accepts unconditionally on the CLK edge where they are high (the slave is
// always ready, there is no back-pressure). For a request accepted at edge N,
// access_err is visible after edge N and read_valid/output_data after edge
// N+1. Both strobes last exactly one cycle.
interface data_mem_mmio_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              read_en;
  logic              write_en;
  logic [DATA_W-1:0] input_data;
  logic [DATA_W-1:0] output_data;
  logic              read_valid;
  logic              access_err;

  modport master (
    output address, read_en, write_en, input_data,
    input  output_data, read_valid, access_err
  );

  modport slave (
    input  address, read_en, write_en, input_data,
    output output_data, read_valid, access_err
  );
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver.
//   CLK, RST_N : clock, asynchronous active-low reset
//   digits     : eight hex nibbles, digit i in digits[4i+3:4i]
//   ctl        : [7:0] digit enables, [15:8] decimal points
//   CA         : segment cathodes {dp,g,f,e,d,c,b,a}, active low
//   AN         : digit anodes, active low, one-hot or all-off
// Each digit slot lasts SCAN_DIV cycles. CA and AN are registered from the
// same next-slot decode, so they always switch on the same edge.
module seg7_scan
  import data_mem_mmio_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] digits,
  input  logic [15:0] ctl,
  output logic [7:0]  CA,
  output logic [7:0]  AN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       ca_q, ca_d;
  logic [7:0]       an_q, an_d;
  logic [3:0]       nib;
  logic [6:0]       glyph;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end
    // Decode from the slot that will be current after this edge so the
    // registered outputs line up with digit_q.
    nib   = digits[{digit_d, 2'b00} +: 4];
    glyph = hex_to_seg(nib);
    an_d  = ctl[{1'b0, digit_d}] ? ~(8'd1 << digit_d) : 8'hFF;
    ca_d  = ~{ctl[{1'b1, digit_d}], glyph};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q   <= '0;
      digit_q <= '0;
      ca_q    <= 8'hFF;
      an_q    <= 8'hFF;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      ca_q    <= ca_d;
      an_q    <= an_d;
    end
  end

  assign CA = ca_q;
  assign AN = an_q;

endmodule

// File: rtl/data_mem_mmio.sv
// Data memory with a 16-word memory-mapped I/O window.
//   CLK, RST_N : clock, asynchronous active-low reset (release is expected
//                to be synchronous to CLK)
//   bus        : load/store port (slave side), see data_mem_mmio_if
//   SW         : 16 board switches, asynchronous
//   BTNS       : 5 board buttons, asynchronous
//   LED        : LED register
//   CA, AN     : seven-segment cathodes/anodes, active low
// Addresses IO_BASE..IO_BASE+15 hit the register window and never the RAM;
// all other addresses hit the RAM. Reads take two edges: the request edge
// captures the data, the following edge presents it with read_valid.
module data_mem_mmio
  import data_mem_mmio_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] IO_BASE  = 8'h40,
  parameter int                SCAN_DIV = 50000
) (
  input  logic              CLK,
  input  logic              RST_N,
  data_mem_mmio_if.slave    bus,
  input  logic [15:0]       SW,
  input  logic [4:0]        BTNS,
  output logic [15:0]       LED,
  output logic [7:0]        CA,
  output logic [7:0]        AN
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Address decode
  logic [ADDR_W-1:0] off_full;
  logic [3:0]        off;
  logic              in_win;
  logic              win_mapped;
  logic              win_wr_ok;
  logic [15:0]       win_rd;
  logic [15:0]       wdata16;
  logic              wr_reg;
  logic              wr_ram;

  // Register file
  logic [15:0] led_q, led_d;
  logic [15:0] seg_lo_q, seg_lo_d;
  logic [15:0] seg_hi_q, seg_hi_d;
  logic [15:0] seg_ctl_q, seg_ctl_d;
  logic [4:0]  btn_edge_q, btn_edge_d;
  logic [4:0]  btn_rise;

  // Input synchronisers; btn_s3_q is the previous synchronised level
  logic [15:0] sw_s1_q, sw_s2_q;
  logic [4:0]  btn_s1_q, btn_s2_q, btn_s3_q;

  // Read pipeline
  logic              rd_pend_q;
  logic              rd_win_q;
  logic [15:0]       win_rd_q;
  logic [DATA_W-1:0] ram_rd_q;
  logic [DATA_W-1:0] out_q;
  logic              rv_q;
  logic              err_q, err_d;

  always_comb begin
    // Subtraction wraps below IO_BASE, so one compare covers both bounds.
    off_full   = bus.address - IO_BASE;
    in_win     = (off_full < ADDR_W'(16));
    off        = off_full[3:0];
    wdata16    = bus.input_data[15:0];
    win_rd     = '0;
    win_mapped = 1'b1;
    win_wr_ok  = 1'b0;
    case (off)
      OFF_LED:      begin win_rd = led_q;      win_wr_ok = 1'b1; end
      OFF_SEG_LO:   begin win_rd = seg_lo_q;   win_wr_ok = 1'b1; end
      OFF_SEG_HI:   begin win_rd = seg_hi_q;   win_wr_ok = 1'b1; end
      OFF_SEG_CTL:  begin win_rd = seg_ctl_q;  win_wr_ok = 1'b1; end
      OFF_BTN_EDGE: begin win_rd = {11'd0, btn_edge_q}; win_wr_ok = 1'b1; end
      OFF_BTN_LVL:  win_rd = {11'd0, btn_s2_q};
      OFF_SW:       win_rd = sw_s2_q;
      default:      win_mapped = 1'b0;
    endcase

    wr_ram = bus.write_en & ~in_win;
    wr_reg = bus.write_en & in_win & win_wr_ok;
    err_d  = (bus.read_en & bus.write_en)
           | (bus.write_en & in_win & ~win_wr_ok)
           | (bus.read_en & in_win & ~win_mapped);

    led_d     = led_q;
    seg_lo_d  = seg_lo_q;
    seg_hi_d  = seg_hi_q;
    seg_ctl_d = seg_ctl_q;
    if (wr_reg) begin
      case (off)
        OFF_LED:     led_d     = wdata16;
        OFF_SEG_LO:  seg_lo_d  = wdata16;
        OFF_SEG_HI:  seg_hi_d  = wdata16;
        OFF_SEG_CTL: seg_ctl_d = wdata16;
        default:     ;
      endcase
    end

    // Clear first, then OR in new edges so a coincident rise survives.
    btn_rise   = btn_s2_q & ~btn_s3_q;
    btn_edge_d = btn_edge_q;
    if (wr_reg && (off == OFF_BTN_EDGE)) begin
      btn_edge_d = btn_edge_q & ~wdata16[4:0];
    end
    btn_edge_d = btn_edge_d | btn_rise;
  end

  // RAM: no reset, read-before-write so a colliding read sees old data.
  always_ff @(posedge CLK) begin
    if (wr_ram) begin
      mem[bus.address] <= bus.input_data;
    end
    if (bus.read_en) begin
      ram_rd_q <= mem[bus.address];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      btn_s3_q   <= '0;
      led_q      <= '0;
      seg_lo_q   <= '0;
      seg_hi_q   <= '0;
      seg_ctl_q  <= '0;
      btn_edge_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_win_q   <= 1'b0;
      win_rd_q   <= '0;
      out_q      <= '0;
      rv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sw_s1_q    <= SW;
      sw_s2_q    <= sw_s1_q;
      btn_s1_q   <= BTNS;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      led_q      <= led_d;
      seg_lo_q   <= seg_lo_d;
      seg_hi_q   <= seg_hi_d;
      seg_ctl_q  <= seg_ctl_d;
      btn_edge_q <= btn_edge_d;
      err_q      <= err_d;
      rd_pend_q  <= bus.read_en;
      if (bus.read_en) begin
        rd_win_q <= in_win;
        win_rd_q <= win_rd;
      end
      rv_q <= rd_pend_q;
      if (rd_pend_q) begin
        out_q <= rd_win_q ? DATA_W'(win_rd_q) : ram_rd_q;
      end
    end
  end

  assign bus.output_data = out_q;
  assign bus.read_valid  = rv_q;
  assign bus.access_err  = err_q;
  assign LED             = led_q;

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .digits ({seg_hi_q, seg_lo_q}),
    .ctl    (seg_ctl_q),
    .CA     (CA),
    .AN     (AN)
  );

endmodule

// File: doc/data_mem_mmio.md
Name: data_mem_mmio

Overview:
Parametrised data memory with a memory-mapped I/O window. It is the next generation of data_mem.
- Adds registered read latency with a read_valid strobe.
- Adds access-error reporting and synchronised switch/button inputs.
- Adds sticky button edge capture and an 8-digit multiplexed seven-segment driver.
- Sits between the CPU datapath load/store port and the board pins.

Parameters:
DATA_W, 16, data word width; must be >= 16
ADDR_W, 8, address width; RAM depth is 2**ADDR_W words
IO_BASE, 8'h40, base of the 16-word I/O window (IO_BASE..IO_BASE+15)
SCAN_DIV, 50000, CLK cycles per seven-segment digit slot; must be >= 2

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
address  in  ADDR_W  word address
read_en  in  1  read request, sampled on CLK
write_en  in  1  write request, sampled on CLK
input_data  in  DATA_W  write data
output_data  out  DATA_W  registered read data
read_valid  out  1  one-cycle pulse: output_data updated
access_err  out  1  one-cycle pulse: illegal or colliding access
SW  in  16  board switches, asynchronous
BTNS  in  5  board buttons, asynchronous
LED  out  16  LED register
CA  out  8  segment cathodes, active low, {dp,g,f,e,d,c,b,a}
AN  out  8  digit anodes, active low, one-hot

Behaviour:
- Reset (async assert, sync release via CLK):
  - output_data=0, read_valid=0, access_err=0, LED=0.
  - SEG_LO=SEG_HI=0, SEG_CTL=0, edge register=0, synchronisers=0.
  - Scan counter=0, digit=0, AN=8'hFF, CA=8'hFF.
  - RAM contents are not reset.
- I/O map, offsets from IO_BASE; unlisted offsets read 0 and write is ignored:
  - 0x4 LED: RW.
  - 0x5 SEG_LO: RW, hex digits 3..0.
  - 0x6 SEG_HI: RW, hex digits 7..4.
  - 0x7 SEG_CTL: RW; [7:0] digit enable, [15:8] decimal points.
  - 0xC BTN_EDGE: read; write-1-to-clear.
  - 0xD BTN_LVL: RO.
  - 0xE SW: RO.
  - Upper DATA_W-16 bits read 0 and are ignored on write.
- RAM: all addresses outside the window. Window addresses never touch RAM.
- Write: takes effect on the CLK edge where write_en=1.
- Read latency: read_en=1 at edge N -> output_data valid and read_valid=1 after edge N+1; output_data holds otherwise.
- read_en and write_en both set in the same cycle:
  - The write is performed.
  - The read returns pre-write data.
  - access_err pulses.
- Writes to RO or unmapped window offsets: ignored, access_err pulses. Reads of unmapped offsets return 0 and pulse access_err.
- SW and BTNS pass through 2-flop synchronisers. A SW read reflects pins from 2 cycles before the read edge.
- BTN_EDGE[i]: set on a synchronised 0->1 of BTNS[i]. Cleared by writing 1 to bit i. Set and clear in the same cycle: set wins.
- LED output is driven directly from the LED register, with no extra latency.
- Seven-segment scan:
  - Counter 0..SCAN_DIV-1; the digit index advances 0..7 and wraps to 0 on the counter terminal value.
  - AN[digit]=0 only if SEG_CTL[digit]=1, else AN=8'hFF for that slot.
  - CA = inverted hex pattern of the nibble, with dp from SEG_CTL[8+digit].
  - CA and AN are registered; they change together, so there is no ghost cycle.
- Reset mid-operation: all state returns to reset values immediately; an in-flight read produces no read_valid.

Decomposition:
- Package data_mem_mmio_pkg holds:
  - the offset constants (OFF_LED, OFF_SEG_LO, OFF_SEG_HI, OFF_SEG_CTL, OFF_BTN_EDGE, OFF_BTN_LVL, OFF_SW);
  - the 16-entry hex-to-segment constant table.
- One sub-module, seg7_scan (CLK, RST_N, digits[31:0], ctl[15:0], CA, AN), parameter SCAN_DIV.
- RAM and the register file stay in the top module.

Test Plan:
- RAM write/read: write 16'hABCD to 8'h74, then read 8'h74 -> read_valid one cycle after the read edge, output_data=16'hABCD, access_err=0.
- LED: write 16'h1234 to 8'h44 -> LED=16'h1234 after the write edge; read 8'h44 returns 16'h1234.
- Read-only protection:
  - With SW=0, write 16'h9876 to 8'h4E -> access_err pulse.
  - Read 8'h4E -> 16'h0000.
  - Set SW=16'h9876, wait 3 cycles, read -> 16'h9876.
- Collision: RAM[8'h10]=16'h0001, then read+write 16'h0002 to 8'h10 in the same cycle -> output_data=16'h0001, access_err pulse; the next read returns 16'h0002.
- Button edge:
  - Pulse BTNS[2] for 3 cycles -> BTN_EDGE reads 5'b00100.
  - Write 16'h0004 to 8'h4C -> reads 0.
  - Rising edge coincident with the clear -> bit stays 1.
- Display, with SCAN_DIV=4:
  - SEG_LO=16'h00A3, SEG_CTL=16'h0103 -> AN cycles 8'hFE (CA=~8'h4F|dp=0 → 8'b0011_0000 i.e. "3" with dp on), then 8'hFD ("A"), then slots 2..7 give AN=8'hFF.
  - The pattern repeats every 32 cycles.
  - Reset mid-scan -> AN=CA=8'hFF immediately.
